// File: rtl/rice_pkg.sv
// Shared types and width helpers for the Rice block decoder.
// Optional raw-block support is compiled in with RICE_BYPASS_EN.
package rice_pkg;

  // Decoder control states; RAW is only reachable with RICE_BYPASS_EN.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FS   = 3'd1,
    REM  = 3'd2,
    DONE = 3'd3,
    RAW  = 3'd4
  } state_e;

  // All-ones k code; truncating to KW bits gives the raw-block selector.
  localparam int unsigned K_BYPASS = 32'hFFFF_FFFF;

  // Sample index width for a block of j samples.
  function automatic int unsigned idx_w(input int unsigned j);
    return (j > 1) ? $clog2(j) : 1;
  endfunction

  // Bit position width inside a buffer of buf_w bits.
  function automatic int unsigned pos_w(input int unsigned buf_w);
    return $clog2(buf_w);
  endfunction

  // Fill counter width: must represent 0..buf_w inclusive.
  function automatic int unsigned fill_w(input int unsigned buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/rice_block_decoder_if.sv
// Start / input-word / output-sample handshake bundle of the Rice block decoder.
interface rice_block_decoder_if #(
  parameter int unsigned KW = 5,
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 16
) ();

  logic          start_valid;
  logic [KW-1:0] start_k;
  logic          start_ready;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          err;

  // Upstream/downstream environment side.
  modport master (
    output start_valid, start_k, in_valid, in_data, out_ready,
    input  start_ready, in_ready, out_valid, out_data, out_last, busy, err
  );

  // Decoder side.
  modport slave (
    input  start_valid, start_k, in_valid, in_data, out_ready,
    output start_ready, in_ready, out_valid, out_data, out_last, busy, err
  );

endinterface

// File: rtl/rice_bit_buffer.sv
// MSB-aligned bit buffer: appends W-bit words behind the valid bits,
// shifts out consumed bits, and reports fill, leading zeros and top bits.
module rice_bit_buffer
  import rice_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned BUF_W  = 64,
  parameter int unsigned N      = 16,
  parameter int unsigned FILL_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              active_i,
  input  logic              in_valid_i,
  input  logic [W-1:0]      in_data_i,
  input  logic [FILL_W-1:0] consume_i,
  output logic              in_ready_o,
  output logic [FILL_W-1:0] fill_o,
  output logic [FILL_W-1:0] lz_o,
  output logic              one_o,
  output logic [N-1:0]      top_o
);

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [BUF_W-1:0]  shifted;
  logic [BUF_W-1:0]  word_al;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] fill_after;
  logic              take;

  assign in_ready_o = active_i && (fill_q <= FILL_W'(BUF_W - W));
  assign take       = in_valid_i && in_ready_o;
  assign fill_o     = fill_q;
  assign top_o      = buf_q[BUF_W-1 -: N];

  // Consume first, then land the new word right after the surviving bits.
  always_comb begin
    shifted    = buf_q << consume_i;
    fill_after = fill_q - consume_i;
    word_al    = {in_data_i, {(BUF_W - W){1'b0}}} >> fill_after;
    buf_d      = shifted;
    fill_d     = fill_after;
    if (take) begin
      buf_d  = shifted | word_al;
      fill_d = fill_after + FILL_W'(W);
    end
  end

  // Leading-zero count; bits below fill are always zero, so an all-zero
  // buffer means no terminating 1 is available yet.
  always_comb begin
    lz_o  = FILL_W'(BUF_W);
    one_o = 1'b0;
    for (int i = 0; i < BUF_W; i++) begin
      if (buf_q[i]) begin
        lz_o  = FILL_W'(BUF_W - 1 - i);
        one_o = 1'b1;
      end
    end
  end

  // Buffer contents and fill count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/rice_block_decoder.sv
// Split-sample Rice block decoder: J FS codes into fs_mem, then J k-bit
// remainders combined into (fs<<k)|rem samples on a valid/ready stream.
// Define RICE_BYPASS_EN to accept start_k all-ones as a raw N-bit block.
module rice_block_decoder
  import rice_pkg::*;
#(
  parameter int unsigned J     = 64,
  parameter int unsigned N     = 16,
  parameter int unsigned W     = 32,
  parameter int unsigned BUF_W = 64,
  parameter int unsigned KW    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rice_block_decoder_if.slave  bus
);

  localparam int unsigned IDX_W  = idx_w(J);
  localparam int unsigned FILL_W = fill_w(BUF_W);
  localparam int unsigned SUM_W  = N + 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(J - 1);
  localparam logic [SUM_W-1:0] FS_MAX   = {2'b00, {N{1'b1}}};
  localparam logic [SUM_W-1:0] ACC_SAT  = {2'b01, {N{1'b0}}};
`ifdef RICE_BYPASS_EN
  localparam logic [KW-1:0]    K_RAW    = KW'(K_BYPASS);
`endif

  state_e             state_q;
  logic [KW-1:0]      k_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SUM_W-1:0]   acc_q;
  logic               drain_q;
  logic               out_valid_q;
  logic [N-1:0]       out_data_q;
  logic               out_last_q;
  logic               err_q;
  logic               start_ready_q;
  logic               busy_q;
  logic [N-1:0]       fs_mem [J];

  logic [FILL_W-1:0]  fill_c;
  logic [FILL_W-1:0]  lz_c;
  logic               one_c;
  logic [N-1:0]       top_c;
  logic [FILL_W-1:0]  consume_c;
  logic [SUM_W-1:0]   fs_sum_c;
  logic [N-1:0]       fs_val_c;
  logic [SUM_W-1:0]   acc_sum_c;
  logic [SUM_W-1:0]   acc_next_c;
  logic [N-1:0]       rem_c;
  logic               stall_c;
  logic               fs_wr_c;
  logic               emit_c;
  logic [N-1:0]       emit_data_c;

  rice_bit_buffer #(
    .W      (W),
    .BUF_W  (BUF_W),
    .N      (N),
    .FILL_W (FILL_W)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .active_i   (state_q != IDLE),
    .in_valid_i (bus.in_valid),
    .in_data_i  (bus.in_data),
    .consume_i  (consume_c),
    .in_ready_o (bus.in_ready),
    .fill_o     (fill_c),
    .lz_o       (lz_c),
    .one_o      (one_c),
    .top_o      (top_c)
  );

  assign bus.start_ready = start_ready_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;

  // Per-cycle decode: how many bits to consume and what to emit.
  always_comb begin
    consume_c   = '0;
    fs_wr_c     = 1'b0;
    emit_c      = 1'b0;
    stall_c     = out_valid_q && !bus.out_ready;
    fs_sum_c    = acc_q + SUM_W'(lz_c);
    fs_val_c    = (fs_sum_c > FS_MAX) ? FS_MAX[N-1:0] : fs_sum_c[N-1:0];
    acc_sum_c   = acc_q + SUM_W'(fill_c);
    acc_next_c  = (acc_sum_c > ACC_SAT) ? ACC_SAT : acc_sum_c;
    rem_c       = top_c >> (N - 32'(k_q));
    emit_data_c = (fs_mem[idx_q] << k_q) | rem_c;
    case (state_q)
      FS: begin
        if (one_c) begin
          consume_c = lz_c + FILL_W'(1);
          fs_wr_c   = 1'b1;
        end else begin
          consume_c = fill_c;
        end
      end
      REM: begin
        if (!drain_q && !stall_c && (fill_c >= FILL_W'(k_q))) begin
          emit_c    = 1'b1;
          consume_c = FILL_W'(k_q);
        end
      end
`ifdef RICE_BYPASS_EN
      RAW: begin
        emit_data_c = top_c;
        if (!drain_q && !stall_c && (fill_c >= FILL_W'(N))) begin
          emit_c    = 1'b1;
          consume_c = FILL_W'(N);
        end
      end
`endif
      default: ;
    endcase
  end

  // FS store; written once per completed code.
  always_ff @(posedge clk) begin
    if (fs_wr_c) begin
      fs_mem[idx_q] <= fs_val_c;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      drain_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      err_q         <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (bus.start_valid && start_ready_q) begin
`ifdef RICE_BYPASS_EN
            if (bus.start_k == K_RAW) begin
              state_q       <= RAW;
              idx_q         <= '0;
              drain_q       <= 1'b0;
              start_ready_q <= 1'b0;
              busy_q        <= 1'b1;
            end else
`endif
            if (32'(bus.start_k) < N) begin
              state_q       <= FS;
              k_q           <= bus.start_k;
              idx_q         <= '0;
              acc_q         <= '0;
              drain_q       <= 1'b0;
              start_ready_q <= 1'b0;
              busy_q        <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FS: begin
          if (one_c) begin
            acc_q <= '0;
            if (fs_sum_c > FS_MAX) begin
              err_q <= 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= REM;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            acc_q <= acc_next_c;
          end
        end
`ifdef RICE_BYPASS_EN
        RAW,
`endif
        REM: begin
          if (emit_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= emit_data_c;
            out_last_q  <= (idx_q == IDX_LAST);
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              drain_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else if (drain_q && out_valid_q && bus.out_ready) begin
            drain_q <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q       <= IDLE;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rice_block_decoder.sv
// Directed bench for rice_block_decoder (J=4, N=16, W=32, BUF_W=64, KW=5).
module tb_rice_block_decoder;

  localparam int unsigned J     = 4;
  localparam int unsigned N     = 16;
  localparam int unsigned W     = 32;
  localparam int unsigned BUF_W = 64;
  localparam int unsigned KW    = 5;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  rice_block_decoder_if #(.KW(KW), .W(W), .N(N)) bus ();

  rice_block_decoder #(
    .J(J), .N(N), .W(W), .BUF_W(BUF_W), .KW(KW)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int cmp_n  = 0;
  int fail_n = 0;
  int err_cnt = 0;

  logic [W-1:0] word_q [$];
  logic [N-1:0] out_q [$];
  logic         last_q [$];
  logic         stall_v [$];
  logic [N-1:0] stall_d [$];

  always @(negedge clk) begin
    if (bus.err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic do_reset();
    reset_n         = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_k     = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_block(input logic [KW-1:0] k);
    int n = 0;
    bus.start_valid = 1'b1;
    bus.start_k     = k;
    while (!bus.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      cmp_n++;
      fail_n++;
      $display("FAIL start_timeout: start_ready=%b want 1", bus.start_ready);
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  task automatic feed(input int gap);
    for (int i = 0; i < word_q.size(); i++) begin
      int n = 0;
      if (i > 0) repeat (gap) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = word_q[i];
      while (!bus.in_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) begin
        cmp_n++;
        fail_n++;
        $display("FAIL feed_timeout: in_ready=%b want 1 (word %0d)", bus.in_ready, i);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic collect(input int n, input int stall_at, input int stall_len);
    int got = 0;
    int t   = 0;
    int st  = 0;
    out_q.delete();
    last_q.delete();
    stall_v.delete();
    stall_d.delete();
    bus.out_ready = 1'b1;
    while (got < n && t < 3000) begin
      @(negedge clk);
      t++;
      if (st > 0) begin
        stall_v.push_back(bus.out_valid);
        stall_d.push_back(bus.out_data);
        st--;
        if (st == 0) bus.out_ready = 1'b1;
      end
      if (st == 0 && bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        got++;
        if (got == stall_at) begin
          @(posedge clk);
          #1 bus.out_ready = 1'b0;
          st = stall_len;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmp_n++; if (bus.start_ready !== 1'b1) begin fail_n++; $display("FAIL rst_start_ready: got %b want 1", bus.start_ready); end
    cmp_n++; if (bus.busy !== 1'b0) begin fail_n++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    cmp_n++; if (bus.out_valid !== 1'b0) begin fail_n++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    cmp_n++; if (bus.out_data !== 16'h0) begin fail_n++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
    cmp_n++; if (bus.out_last !== 1'b0) begin fail_n++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
    cmp_n++; if (bus.err !== 1'b0) begin fail_n++; $display("FAIL rst_err: got %b want 0", bus.err); end
    cmp_n++; if (bus.in_ready !== 1'b0) begin fail_n++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [N-1:0] exp_d [4];
    int base;
    exp_d = '{16'd3, 16'd4, 16'd10, 16'd13};
    do_reset();
    base = err_cnt;
    word_q = '{32'hA472_4000};
    start_block(5'd2);
    fork
      feed(0);
      collect(4, 0, 0);
    join
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL basic_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_d[i]) begin fail_n++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, out_q[i], exp_d[i]); end
      cmp_n++; if (last_q[i] !== (i == 3)) begin fail_n++; $display("FAIL basic_last[%0d]: got %b want %b", i, last_q[i], (i == 3)); end
    end
    repeat (2) @(negedge clk);
    cmp_n++; if (err_cnt - base !== 0) begin fail_n++; $display("FAIL basic_err: got %0d pulses want 0", err_cnt - base); end
  endtask

  task automatic test_long_fs();
    logic [N-1:0] exp_d [4];
    int base;
    exp_d = '{16'd70, 16'd0, 16'd2, 16'd1};
    do_reset();
    base = err_cnt;
    word_q = '{32'h0000_0000, 32'h0000_0000, 32'h0328_0000};
    start_block(5'd0);
    fork
      feed(0);
      collect(4, 0, 0);
    join
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL longfs_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_d[i]) begin fail_n++; $display("FAIL longfs_data[%0d]: got %0d want %0d", i, out_q[i], exp_d[i]); end
    end
    cmp_n++; if (last_q[3] !== 1'b1) begin fail_n++; $display("FAIL longfs_last: got %b want 1", last_q[3]); end
    repeat (2) @(negedge clk);
    cmp_n++; if (err_cnt - base !== 0) begin fail_n++; $display("FAIL longfs_err: got %0d pulses want 0", err_cnt - base); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_d [4];
    exp_d = '{16'h02A5, 16'h003C, 16'h01FF, 16'h0301};
    do_reset();
    word_q = '{32'h3469_4F3F, 32'hC040_0000};
    start_block(5'd8);
    fork
      feed(3);
      collect(4, 1, 5);
    join
    cmp_n++; if (stall_v.size() !== 5) begin fail_n++; $display("FAIL bp_stall_len: got %0d want 5", stall_v.size()); end
    for (int i = 0; i < stall_v.size(); i++) begin
      cmp_n++; if (stall_v[i] !== 1'b1) begin fail_n++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, stall_v[i]); end
      cmp_n++; if (stall_d[i] !== 16'h003C) begin fail_n++; $display("FAIL bp_hold_data[%0d]: got %h want 003c", i, stall_d[i]); end
    end
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL bp_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_d[i]) begin fail_n++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_q[i], exp_d[i]); end
    end
    cmp_n++; if (last_q[3] !== 1'b1) begin fail_n++; $display("FAIL bp_last: got %b want 1", last_q[3]); end
  endtask

  task automatic test_bad_k();
    do_reset();
    start_block(5'd16);
    cmp_n++; if (bus.err !== 1'b1) begin fail_n++; $display("FAIL badk_err: got %b want 1", bus.err); end
    @(negedge clk);
    cmp_n++; if (bus.err !== 1'b0) begin fail_n++; $display("FAIL badk_err_pulse: got %b want 0", bus.err); end
    cmp_n++; if (bus.busy !== 1'b0) begin fail_n++; $display("FAIL badk_busy: got %b want 0", bus.busy); end
    cmp_n++; if (bus.start_ready !== 1'b1) begin fail_n++; $display("FAIL badk_start_ready: got %b want 1", bus.start_ready); end
`ifndef RICE_BYPASS_EN
    start_block(5'd31);
    cmp_n++; if (bus.err !== 1'b1) begin fail_n++; $display("FAIL badk31_err: got %b want 1", bus.err); end
    @(negedge clk);
    cmp_n++; if (bus.busy !== 1'b0) begin fail_n++; $display("FAIL badk31_busy: got %b want 0", bus.busy); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_d [4];
    exp_d = '{16'd3, 16'd4, 16'd10, 16'd13};
    do_reset();
    word_q = '{32'hA472_4000};
    start_block(5'd2);
    fork
      feed(0);
      collect(2, 0, 0);
    join
    bus.out_ready = 1'b0;
    cmp_n++; if (bus.busy !== 1'b1) begin fail_n++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    cmp_n++; if (bus.out_valid !== 1'b0) begin fail_n++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    cmp_n++; if (bus.busy !== 1'b0) begin fail_n++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    cmp_n++; if (bus.start_ready !== 1'b1) begin fail_n++; $display("FAIL mid_start_ready: got %b want 1", bus.start_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    word_q = '{32'hA472_4000};
    start_block(5'd2);
    fork
      feed(0);
      collect(4, 0, 0);
    join
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL mid_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_d[i]) begin fail_n++; $display("FAIL mid_data[%0d]: got %0d want %0d", i, out_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_a [4];
    logic [N-1:0] exp_b [4];
    exp_a = '{16'd3, 16'd0, 16'd1, 16'd5};
    exp_b = '{16'd0, 16'd1, 16'd0, 16'd0};
    do_reset();
    word_q = '{32'h7377_0000};
    start_block(5'd1);
    fork
      feed(0);
      collect(4, 0, 0);
    join
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL b2b_a_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_a[i]) begin fail_n++; $display("FAIL b2b_a_data[%0d]: got %0d want %0d", i, out_q[i], exp_a[i]); end
      cmp_n++; if (last_q[i] !== (i == 3)) begin fail_n++; $display("FAIL b2b_a_last[%0d]: got %b want %b", i, last_q[i], (i == 3)); end
    end
    word_q.delete();
    start_block(5'd0);
    collect(4, 0, 0);
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL b2b_b_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_b[i]) begin fail_n++; $display("FAIL b2b_b_data[%0d]: got %0d want %0d", i, out_q[i], exp_b[i]); end
    end
    cmp_n++; if (last_q[3] !== 1'b1) begin fail_n++; $display("FAIL b2b_b_last: got %b want 1", last_q[3]); end
  endtask

`ifdef RICE_BYPASS_EN
  task automatic test_bypass();
    logic [N-1:0] exp_d [4];
    exp_d = '{16'hABCD, 16'h1234, 16'h5678, 16'h9ABC};
    do_reset();
    word_q = '{32'hABCD_1234, 32'h5678_9ABC};
    start_block(5'd31);
    fork
      feed(0);
      collect(4, 0, 0);
    join
    cmp_n++; if (out_q.size() !== 4) begin fail_n++; $display("FAIL raw_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (out_q[i] !== exp_d[i]) begin fail_n++; $display("FAIL raw_data[%0d]: got %h want %h", i, out_q[i], exp_d[i]); end
    end
    cmp_n++; if (last_q[3] !== 1'b1) begin fail_n++; $display("FAIL raw_last: got %b want 1", last_q[3]); end
  endtask
`endif

  initial begin
    reset_n         = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_k     = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_long_fs();
    test_backpressure();
    test_bad_k();
    test_reset_mid();
    test_back_to_back();
`ifdef RICE_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

// File: doc/rice_block_decoder.md
Name: rice_block_decoder

Overview:
- Parametrised successor of the OR-plane Rice decoder. Decodes one CCSDS-style split-sample block of J samples from a packed 32-bit word stream.
- Phase 1 decodes J fundamental-sequence (FS) codes into a local FS store. Phase 2 reads J k-bit remainders and emits reconstructed samples, (fs<<k)|rem, on a valid/ready stream.
- Sits between the telemetry word unpacker and the predictor/unmapper stage.
- Adds over the previous generation:
  - input and output back-pressure;
  - FS codes longer than the bit buffer;
  - parametrised J and sample width;
  - end-of-block marking and error reporting.

Parameters:
- J, 64, samples per block (2..64).
- N, 16, output sample width in bits (8..32).
- W, 32, input word width.
- BUF_W, 64, bit-buffer width; must be at least 2*W.
- KW, 5, width of the k field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start_valid  in  1  new block request.
- start_k  in  KW  split parameter for the block.
- start_ready  out  1  high only in IDLE.
- in_valid  in  1  input word valid.
- in_data  in  W  packed bits, MSB first.
- in_ready  out  1  buffer can take a word.
- out_valid  out  1  sample valid.
- out_data  out  N  decoded sample.
- out_last  out  1  marks sample J-1 of the block.
- out_ready  in  1  downstream accept.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, buffer fill=0, FS accumulator=0, sample index=0.
  - All outputs 0 except start_ready=1.
- Bit buffer:
  - MSB-aligned, holds `fill` valid bits.
  - in_ready = (fill <= BUF_W-W) and state != IDLE.
  - On in_valid&&in_ready the word is appended at bit position fill. Consume and append may occur in the same cycle; the appended word lands after the consumed bits are shifted out.
- States: IDLE, FS, REM, DONE.
- IDLE:
  - Block starts on start_valid&&start_ready.
  - start_k=0..N-1 is latched as k; go to FS.
  - start_k>=N (when not a bypass code): err pulses and the request is ignored.
  - Leftover buffer bits are kept across blocks; blocks are bit-contiguous.
- FS (one code per cycle at most):
  - lz = leading zeros in the fill valid bits.
  - If a 1 is present: fs = acc+lz, consume lz+1, write fs_mem[idx], acc=0, idx++.
  - If no 1 is present: acc += fill, consume fill.
  - If acc+lz exceeds 2^N-1: err pulses, fs saturates to 2^N-1.
  - After idx reaches J-1 and is written: idx=0, go to REM.
- REM:
  - When fill>=k and the output is not stalled: rem = top k bits, consume k.
  - out_data = (fs_mem[idx]<<k)|rem, truncated to N bits; out_valid=1.
  - k=0 emits fs_mem[idx] with no consumption.
- Output register:
  - out_valid is held with out_data stable until out_ready.
  - One sample per cycle maximum.
  - out_last=1 on idx=J-1.
  - After the last handshake, go to DONE.
- DONE: one cycle, then IDLE. start_ready rises the next cycle.
- Latency: first sample appears ≥2 cycles after the final FS code is written.
- Simultaneous events: in_valid is ignored in IDLE (in_ready=0). start_valid is ignored unless in IDLE.

Optional Feature:
- Macro: RICE_BYPASS_EN.
- Defined:
  - start_k all-ones (2^KW-1) selects a raw block, state RAW.
  - FS is skipped. Each sample is the next N bits, consumed when fill>=N.
  - Same handshake and out_last behaviour as REM.
- Not defined: the all-ones k follows the normal rule (err if >=N), and the RAW state and its logic are absent.

Decomposition:
- Package rice_pkg holds:
  - state enum (IDLE, FS, REM, DONE, RAW);
  - K_BYPASS constant;
  - localparam helpers for clog2 widths of J, BUF_W and the fill counter.
- One sub-module, rice_bit_buffer. It contains the append/consume shift register, fill counter, in_ready and the leading-zero counter. It outputs top bits, fill and lz.
- fs_mem is a J×N register array in the top level.

Test Plan:
- Basic decode:
  - Stimulus: J=4, k=2, bits `1 01 001 0001` then remainders `11 00 10 01`, packed MSB-first in one word.
  - Required response: outputs 3,4,10,13; out_last on the 4th sample; err=0.
- Long FS:
  - Stimulus: J=2, k=0, FS of 70 zeros then 1 across 3 words, then `1`.
  - Required response: outputs 70, 0.
- Back-pressure:
  - Stimulus: out_ready low for 5 cycles mid-REM.
  - Required response: out_data/out_valid stable; no bits lost. in_valid gaps of 3 cycles cause no corruption.
- Bad k: start_k=N with bypass disabled -> one err pulse; state stays IDLE.
- Reset mid-operation: reset_n low during REM at idx=5 -> immediate IDLE, fill=0, out_valid=0; the next block decodes correctly.
- Bypass (RICE_BYPASS_EN): start_k=31, N=16, word 0xABCD1234 -> outputs 0xABCD, 0x1234.
